my_stopwatch: RTL and testbench



---
 rtl/my_stopwatch.sv | 259 +++++++++++++++++++++++++
 tb/tb_my_stopwatch.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/my_stopwatch.sv
// my_stopwatch: two-button seconds stopwatch (00-59) with a 5-entry lap memory.
// It drives a two-digit, time-multiplexed 7-segment display.
//
// Ports:
//   CLK  - system clock
//   RST  - synchronous, active-high reset
//   BTN0 - raw button: press = start/stop, long hold (from STOP) = lap review
//   BTN1 - raw button: press = save lap (running) / next lap (review),
//          long hold = clear (from STOP or review)
//   AN   - segment pattern {g,f,e,d,c,b,a}, active-high, registered
//   CA   - digit select: 0 = ones digit, 1 = tens digit
//
// Parameters:
//   CLK_FREQ  - clock cycles per second (>= 10); a long hold is 3*CLK_FREQ cycles
//   LAP_DEPTH - number of stored laps; the oldest entry is dropped on overflow
//
// Optional feature macro: BLANK_LEAD_ZERO_EN
//   When defined, a zero tens digit is blanked instead of showing "0".
module my_stopwatch #(
    parameter int CLK_FREQ  = 125_000_000,
    parameter int LAP_DEPTH = 5
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       BTN0,
    input  logic       BTN1,
    output logic [6:0] AN,
    output logic       CA
);

    localparam int LONG_CYC = 3 * CLK_FREQ;
    localparam int HOLD_W   = $clog2(LONG_CYC + 1);
    localparam int PRE_W    = $clog2(CLK_FREQ);
    localparam int MUX_DIV  = (CLK_FREQ / 1000 > 1) ? (CLK_FREQ / 1000) : 1;
    localparam int MUX_W    = $clog2(MUX_DIV + 1);
    localparam int CNT_W    = $clog2(LAP_DEPTH + 1);
    localparam int PTR_W    = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;
    localparam int IDX_W    = $clog2(2 * LAP_DEPTH + 1);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYC - 1);
    localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(LONG_CYC);
    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(CLK_FREQ - 1);
    localparam logic [MUX_W-1:0]  MUX_LAST  = MUX_W'(MUX_DIV - 1);
    localparam logic [CNT_W-1:0]  LAP_FULL  = CNT_W'(LAP_DEPTH);

    typedef enum logic [1:0] {S_CLEAR, S_START, S_STOP, S_LOAD} state_t;

    // ------------------------------------------------------------------
    // Button conditioning: 2-FF synchronizer, rising-edge press, hold timer.
    // Index 0 = BTN0, index 1 = BTN1.
    // ------------------------------------------------------------------
    logic [1:0] btn_raw;
    logic [1:0] press;
    logic [1:0] long_evt;

    assign btn_raw = {BTN1, BTN0};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            logic              meta_reg;
            logic              sync_reg;
            logic              prev_reg;
            logic [HOLD_W-1:0] hold_reg;

            always_ff @(posedge CLK) begin
                if (RST) begin
                    meta_reg <= 1'b0;
                    sync_reg <= 1'b0;
                    prev_reg <= 1'b0;
                    hold_reg <= '0;
                end else begin
                    meta_reg <= btn_raw[gi];
                    sync_reg <= meta_reg;
                    prev_reg <= sync_reg;
                    // Saturating one past the terminal value makes the long
                    // event a single-cycle pulse however long the hold lasts.
                    if (!sync_reg) begin
                        hold_reg <= '0;
                    end else if (hold_reg != HOLD_SAT) begin
                        hold_reg <= hold_reg + HOLD_W'(1);
                    end
                end
            end

            assign press[gi]    = sync_reg & ~prev_reg;
            assign long_evt[gi] = sync_reg && (hold_reg == HOLD_LAST);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    state_t state_reg, state_next;
    logic   lap_push;
    logic   view_first;
    logic   view_step;
    logic   clear_all;
    logic   lap_view_reg;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= S_CLEAR;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        lap_push   = 1'b0;
        view_first = 1'b0;
        view_step  = 1'b0;
        case (state_reg)
            S_CLEAR: begin
                if (press[0]) state_next = S_START;
            end
            S_START: begin
                // BTN0 wins a same-cycle collision, so no lap is stored.
                if (press[0])      state_next = S_STOP;
                else if (press[1]) lap_push   = 1'b1;
            end
            S_STOP: begin
                if (press[0])         state_next = S_START;
                else if (long_evt[0]) state_next = S_LOAD;
                else if (long_evt[1]) state_next = S_CLEAR;
            end
            S_LOAD: begin
                if (long_evt[1]) begin
                    state_next = S_CLEAR;
                end else if (press[1]) begin
                    // The first press swaps the frozen time for the oldest lap.
                    if (!lap_view_reg) view_first = 1'b1;
                    else               view_step  = 1'b1;
                end
            end
            default: state_next = S_CLEAR;
        endcase
        clear_all = (state_next == S_CLEAR);
    end

    // ------------------------------------------------------------------
    // Timebase and lap memory (circular buffer, head = oldest entry)
    // ------------------------------------------------------------------
    logic [PRE_W-1:0] presc_reg;
    logic [5:0]       sec_reg;
    logic [PTR_W-1:0] head_reg;
    logic [CNT_W-1:0] count_reg;
    logic [PTR_W-1:0] cursor_reg;
    logic [5:0]       lap_mem [LAP_DEPTH];
    logic [IDX_W-1:0] wr_sum, rd_sum, head_sum;
    logic [PTR_W-1:0] wr_idx, rd_idx, head_inc;
    logic [CNT_W-1:0] cursor_inc;

    always_comb begin
        wr_sum   = IDX_W'(head_reg) + IDX_W'(count_reg);
        rd_sum   = IDX_W'(head_reg) + IDX_W'(cursor_reg);
        head_sum = IDX_W'(head_reg) + IDX_W'(1);
        wr_idx   = (wr_sum >= IDX_W'(LAP_DEPTH)) ? PTR_W'(wr_sum - IDX_W'(LAP_DEPTH))
                                                 : PTR_W'(wr_sum);
        rd_idx   = (rd_sum >= IDX_W'(LAP_DEPTH)) ? PTR_W'(rd_sum - IDX_W'(LAP_DEPTH))
                                                 : PTR_W'(rd_sum);
        head_inc = (head_sum >= IDX_W'(LAP_DEPTH)) ? '0 : PTR_W'(head_sum);
        cursor_inc = CNT_W'(cursor_reg) + CNT_W'(1);
    end

    always_ff @(posedge CLK) begin
        if (RST || clear_all) begin
            presc_reg    <= '0;
            sec_reg      <= '0;
            head_reg     <= '0;
            count_reg    <= '0;
            cursor_reg   <= '0;
            lap_view_reg <= 1'b0;
        end else begin
            if (state_reg == S_START) begin
                if (presc_reg == PRE_LAST) begin
                    presc_reg <= '0;
                    sec_reg   <= (sec_reg == 6'd59) ? 6'd0 : sec_reg + 6'd1;
                end else begin
                    presc_reg <= presc_reg + PRE_W'(1);
                end
            end
            if (lap_push) begin
                // When full, the new entry overwrites the oldest slot.
                if (count_reg == LAP_FULL) head_reg  <= head_inc;
                else                       count_reg <= count_reg + CNT_W'(1);
            end
            if (view_first) begin
                lap_view_reg <= 1'b1;
                cursor_reg   <= '0;
            end else if (view_step) begin
                cursor_reg <= (cursor_inc >= count_reg) ? '0 : PTR_W'(cursor_inc);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST && lap_push) begin
            lap_mem[wr_idx] <= sec_reg;
        end
    end

    // ------------------------------------------------------------------
    // Display multiplexer
    // ------------------------------------------------------------------
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h3F;
            4'd1:    seg7 = 7'h06;
            4'd2:    seg7 = 7'h5B;
            4'd3:    seg7 = 7'h4F;
            4'd4:    seg7 = 7'h66;
            4'd5:    seg7 = 7'h6D;
            4'd6:    seg7 = 7'h7D;
            4'd7:    seg7 = 7'h07;
            4'd8:    seg7 = 7'h7F;
            4'd9:    seg7 = 7'h6F;
            default: seg7 = 7'h00;
        endcase
    endfunction

    logic [5:0]       disp_val;
    logic [3:0]       tens, ones;
    logic [MUX_W-1:0] div_reg;
    logic             ca_reg, ca_next;
    logic [6:0]       an_reg, an_next;

    always_comb begin
        disp_val = sec_reg;
        if (state_reg == S_LOAD && lap_view_reg) begin
            disp_val = (count_reg == '0) ? 6'd0 : lap_mem[rd_idx];
        end
        tens    = 4'(disp_val / 6'd10);
        ones    = 4'(disp_val % 6'd10);
        ca_next = (div_reg == MUX_LAST) ? ~ca_reg : ca_reg;
        // AN is computed for the digit CA will select after this edge.
        an_next = seg7(ca_next ? tens : ones);
`ifdef BLANK_LEAD_ZERO_EN
        if (ca_next && tens == 4'd0) an_next = 7'h00;
`endif
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            div_reg <= '0;
            ca_reg  <= 1'b0;
            an_reg  <= 7'h3F;
        end else begin
            div_reg <= (div_reg == MUX_LAST) ? '0 : div_reg + MUX_W'(1);
            ca_reg  <= ca_next;
            an_reg  <= an_next;
        end
    end

    assign CA = ca_reg;
    assign AN = an_reg;

endmodule

// File: tb/tb_my_stopwatch.sv
// Testbench for my_stopwatch. A reference model tracks the stopwatch as
// abstract quantities (elapsed hold lengths, seconds, a lap queue) and
// queues the expected {CA, AN} after each clock edge; a monitor compares.
module tb_my_stopwatch;

    localparam int CF   = 20;
    localparam int LD   = 5;
    localparam int LONG = 3 * CF;
    localparam int MUXD = (CF / 1000 > 1) ? (CF / 1000) : 1;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;
    localparam int M_REV  = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       b0  = 1'b0;
    logic       b1  = 1'b0;
    logic [6:0] an;
    logic       ca;

    my_stopwatch #(.CLK_FREQ(CF), .LAP_DEPTH(LD)) dut (
        .CLK (clk),
        .RST (rst),
        .BTN0(b0),
        .BTN1(b1),
        .AN  (an),
        .CA  (ca)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       ca;
        logic [6:0] an;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    // Model state
    int m_s1 [2];
    int m_s2 [2];
    int m_run [2];     // length of the current synchronized hold, in cycles
    int m_state;
    int m_sec;
    int m_pre;
    int laps[$];       // oldest first
    int m_view;        // -1: show time, else index into laps
    int m_cyc;

    always @(posedge clk) begin : model
        exp_t       e;
        int         disp;
        int         st;
        int         dig;
        bit         p [2];
        bit         lg [2];
        logic [1:0] raw;
        raw = {b1, b0};
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                m_s1[k] = 0; m_s2[k] = 0; m_run[k] = 0;
            end
            m_state = M_IDLE;
            m_sec = 0; m_pre = 0; m_view = -1; m_cyc = 0;
            laps.delete();
            e.ca = 1'b0;
            e.an = 7'h3F;
        end else begin
            disp = m_sec;
            if (m_state == M_REV && m_view >= 0)
                disp = (laps.size() == 0) ? 0 : laps[m_view];
            for (int k = 0; k < 2; k++) begin
                m_run[k] = (m_s2[k] != 0) ? m_run[k] + 1 : 0;
                p[k]  = (m_run[k] == 1);
                lg[k] = (m_run[k] == LONG);
                m_s2[k] = m_s1[k];
                m_s1[k] = int'(raw[k]);
            end
            st = m_state;
            case (st)
                M_IDLE: if (p[0]) m_state = M_RUN;
                M_RUN: begin
                    if (p[0]) m_state = M_HALT;
                    else if (p[1]) begin
                        laps.push_back(m_sec);
                        if (laps.size() > LD) void'(laps.pop_front());
                    end
                end
                M_HALT: begin
                    if (p[0]) m_state = M_RUN;
                    else if (lg[0]) begin m_state = M_REV; m_view = -1; end
                    else if (lg[1]) m_state = M_IDLE;
                end
                default: begin
                    if (lg[1]) m_state = M_IDLE;
                    else if (p[1]) begin
                        if (m_view < 0 || laps.size() == 0) m_view = 0;
                        else m_view = (m_view + 1) % laps.size();
                    end
                end
            endcase
            if (st == M_RUN) begin
                m_pre++;
                if (m_pre == CF) begin
                    m_pre = 0;
                    m_sec = (m_sec + 1) % 60;
                end
            end
            if (m_state == M_IDLE) begin
                m_sec = 0; m_pre = 0; m_view = -1;
                laps.delete();
            end
            m_cyc++;
            e.ca = (((m_cyc / MUXD) % 2) == 1);
            dig  = e.ca ? disp / 10 : disp % 10;
            e.an = seg_tab[dig];
`ifdef BLANK_LEAD_ZERO_EN
            if (e.ca && disp / 10 == 0) e.an = 7'h00;
`endif
        end
        sb.push_back(e);
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (ca !== e.ca || an !== e.an) begin
                failures++;
                $display("FAIL display t=%0t got ca=%0b an=%02h expected ca=%0b an=%02h",
                         $time, ca, an, e.ca, e.an);
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // which: 1 = BTN0, 2 = BTN1, 3 = both
    task automatic hold(input int which, input int len, input string tag);
        @(negedge clk);
        b0 = (which & 1) != 0;
        b1 = (which & 2) != 0;
        cycles(len);
        b0 = 1'b0;
        b1 = 1'b0;
        $display("tb: %s btn=%0d len=%0d model_sec=%0d laps=%0d t=%0t",
                 tag, which, len, m_sec, laps.size(), $time);
    endtask

    initial begin : stim
        int sel, len;
        rst = 1'b1;
        cycles(5);
        rst = 1'b0;

        // Start, run past the 59 -> 00 wrap
        hold(1, 10, "start");
        cycles(65 * CF - 10);
        // Stop, freeze, long-hold BTN1 to clear
        hold(1, 2, "stop");
        cycles(5 * CF);
        hold(2, LONG + 10, "clear");
        cycles(20);
        hold(2, 3, "lap-in-clear");
        cycles(20);

        // Restart and record six laps; the first is overwritten
        hold(1, 3, "restart");
        cycles(5 * CF - 3);
        hold(2, 3, "lap");
        cycles(15 * CF - 3);
        for (int i = 0; i < 5; i++) begin
            hold(2, 3, "lap");
            cycles(5 * CF - 3);
        end
        // Hold BTN0: stop then review
        hold(1, LONG + 20, "review");
        cycles(10);
        for (int i = 0; i < 7; i++) begin
            hold(2, 3, "next-lap");
            cycles(10);
        end
        hold(2, LONG + 5, "clear");
        cycles(10);

        // Simultaneous presses while running
        hold(1, 3, "start");
        cycles(2 * CF);
        hold(3, 3, "both");
        cycles(CF);
        hold(1, 3, "resume");
        cycles(CF);

        // Random button activity
        repeat (60) begin
            sel = int'($urandom_range(1, 3));
            if ($urandom_range(0, 3) == 0) len = int'($urandom_range(LONG - 5, LONG + 30));
            else                           len = int'($urandom_range(1, 8));
            hold(sel, len, "random");
            cycles(int'($urandom_range(1, 3 * CF)));
        end

        // Reset while running
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        hold(1, 3, "start");
        cycles(3 * CF);
        @(negedge clk); rst = 1'b1;
        $display("tb: reset-in-start t=%0t", $time);
        @(negedge clk); rst = 1'b0;
        cycles(10);

        cycles(3);
        checks++;
        if (sb.size() > 1) begin
            failures++;
            $display("FAIL scoreboard-drain got %0d pending expected <=1", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
